// File: rtl/fsk_tx_pkg.sv
// Shared state encoding, frame layout constants and helpers for the FSK transmitter sequencer.
package fsk_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ENCRYPT,
        TRANSMIT
    } seqState_e;

    localparam int FRAME_BYTES = 19;
    localparam int BLOCK_BITS  = 128;
    localparam int IDX_SYM_MSB = 16;
    localparam int IDX_SYM_LSB = 17;
    localparam int IDX_REP     = FRAME_BYTES - 1;

    // A repetition factor of zero would never finish a bit, so it behaves as one.
    function automatic logic [7:0] effRep(input logic [7:0] rep);
        return (rep == 8'd0) ? 8'd1 : rep;
    endfunction

endpackage

// File: rtl/fsk_frame_sequencer_if.sv
// Bundle of UART, AES and modulator signals seen by the frame sequencer.
interface fsk_frame_sequencer_if;
    import fsk_tx_pkg::*;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [BLOCK_BITS-1:0] aes_block;
    logic                  aes_start;
    logic                  aes_done;
    logic [BLOCK_BITS-1:0] aes_result;
    logic [15:0]           sym_time;
    logic                  bit_data;
    logic                  bit_valid;
    logic                  bit_ready;
    logic                  busy;
    logic                  overrun;

    // master is the sequencer itself, slave is the UART/AES/modulator side
    modport master (
        input  rx_data, rx_valid, aes_done, aes_result, bit_ready,
        output aes_block, aes_start, sym_time, bit_data, bit_valid, busy, overrun
    );

    modport slave (
        output rx_data, rx_valid, aes_done, aes_result, bit_ready,
        input  aes_block, aes_start, sym_time, bit_data, bit_valid, busy, overrun
    );

endinterface

// File: rtl/fsk_bit_serializer.sv
// Shifts a ciphertext block out MSB-first over a valid/ready link, repeating each bit.
module fsk_bit_serializer
    import fsk_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [BLOCK_BITS-1:0] i_block,
    input  logic [7:0]            i_rep,
    input  logic                  i_ready,
    output logic                  o_bitData,
    output logic                  o_bitValid,
    output logic                  o_done
);

    logic [BLOCK_BITS-1:0] r_shreg;
    logic [7:0]            r_repCnt;
    logic [6:0]            r_bitCnt;
    logic                  r_valid;
    logic                  w_xfer;
    logic                  w_repEnd;
    logic [7:0]            w_repNext;

    assign w_xfer     = r_valid && i_ready;
    assign w_repNext  = r_repCnt + 8'd1;
    assign w_repEnd   = (w_repNext == effRep(i_rep));
    assign o_done     = w_xfer && w_repEnd && (r_bitCnt == 7'd127);
    assign o_bitData  = r_shreg[BLOCK_BITS-1];
    assign o_bitValid = r_valid;

    // The bit only advances once it has been accepted eff_rep times in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_repCnt <= '0;
            r_bitCnt <= '0;
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_shreg  <= i_block;
            r_repCnt <= '0;
            r_bitCnt <= '0;
            r_valid  <= 1'b1;
        end else if (w_xfer) begin
            if (w_repEnd) begin
                r_shreg  <= {r_shreg[BLOCK_BITS-2:0], 1'b0};
                r_repCnt <= '0;
                r_bitCnt <= r_bitCnt + 7'd1;
                if (r_bitCnt == 7'd127) begin
                    r_valid <= 1'b0;
                end
            end else begin
                r_repCnt <= w_repNext;
            end
        end
    end

endmodule

// File: rtl/fsk_frame_sequencer.sv
// Collects a 19-byte host frame, launches AES and streams the ciphertext to the FSK modulator.
// Optional inter-byte timeout during collection is enabled with FSK_SEQ_TIMEOUT_EN.
module fsk_frame_sequencer
    import fsk_tx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4800000
) (
    input logic                   M_CLK_OSC,
    input logic                   M_RESET,
    fsk_frame_sequencer_if.master bus
);

    seqState_e             r_state;
    logic [4:0]            r_byteCnt;
    logic [BLOCK_BITS-1:0] r_aesBlock;
    logic [15:0]           r_symTime;
    logic [7:0]            r_rep;
    logic                  r_aesStart;
    logic                  r_overrun;
    logic                  w_load;
    logic                  w_done;
    logic                  w_timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8388607) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must fit the 23-bit idle counter");
    end

`ifdef FSK_SEQ_TIMEOUT_EN
    logic [22:0] r_idleCnt;

    assign w_timeout = (r_state == COLLECT) && !bus.rx_valid &&
                       (r_idleCnt == 23'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge M_CLK_OSC) begin
        if (M_RESET || (r_state != COLLECT) || bus.rx_valid) begin
            r_idleCnt <= '0;
        end else begin
            r_idleCnt <= r_idleCnt + 23'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_load = (r_state == ENCRYPT) && bus.aes_done;

    // Frame capture and sequencing; bytes seen outside IDLE/COLLECT only raise overrun.
    always_ff @(posedge M_CLK_OSC) begin
        if (M_RESET) begin
            r_state    <= IDLE;
            r_byteCnt  <= '0;
            r_aesBlock <= '0;
            r_symTime  <= '0;
            r_rep      <= '0;
            r_aesStart <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_aesStart <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        r_aesBlock[BLOCK_BITS-1 -: 8] <= bus.rx_data;
                        r_byteCnt <= 5'd1;
                        r_overrun <= 1'b0;
                        r_state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_timeout) begin
                        r_byteCnt <= '0;
                        r_state   <= IDLE;
                    end else if (bus.rx_valid) begin
                        if (r_byteCnt == 5'(IDX_SYM_MSB)) begin
                            r_symTime[15:8] <= bus.rx_data;
                        end else if (r_byteCnt == 5'(IDX_SYM_LSB)) begin
                            r_symTime[7:0] <= bus.rx_data;
                        end else if (r_byteCnt == 5'(IDX_REP)) begin
                            r_rep <= bus.rx_data;
                        end else begin
                            r_aesBlock[{~r_byteCnt[3:0], 3'b000} +: 8] <= bus.rx_data;
                        end
                        if (r_byteCnt == 5'(IDX_REP)) begin
                            r_byteCnt  <= '0;
                            r_aesStart <= 1'b1;
                            r_state    <= ENCRYPT;
                        end else begin
                            r_byteCnt <= r_byteCnt + 5'd1;
                        end
                    end
                end
                ENCRYPT: begin
                    if (bus.rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (bus.aes_done) begin
                        r_state <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (bus.rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fsk_bit_serializer u_serializer (
        .clk        (M_CLK_OSC),
        .rst        (M_RESET),
        .i_load     (w_load),
        .i_block    (bus.aes_result),
        .i_rep      (r_rep),
        .i_ready    (bus.bit_ready),
        .o_bitData  (bus.bit_data),
        .o_bitValid (bus.bit_valid),
        .o_done     (w_done)
    );

    assign bus.aes_block = r_aesBlock;
    assign bus.aes_start = r_aesStart;
    assign bus.sym_time  = r_symTime;
    assign bus.busy      = (r_state != IDLE);
    assign bus.overrun   = r_overrun;

endmodule

// File: doc/fsk_frame_sequencer.md
# fsk_frame_sequencer

Control sequencer between the UART receiver, the AES core and the FSK modulator in the singing-FPGA transmitter. It assembles a 19-byte host frame: 16 payload bytes, then a 16-bit symbol time, then an 8-bit repetition factor. It launches one AES encryption of the payload, then feeds the 128 ciphertext bits to the modulator MSB-first, repeating each bit the requested number of times. It owns all sequencing; the modulator only times individual symbols.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4800000 — inter-byte idle limit during frame collection (100 ms at 48 MHz); used only with the timeout feature.

Ports:
- M_CLK_OSC  in  1  system clock, 48 MHz.
- M_RESET  in  1  reset; synchronous, active-high.
- rx_data  in  8  byte from UART RX.
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- aes_block  out  128  plaintext to AES; first received byte lands in [127:120].
- aes_start  out  1  one-cycle start pulse.
- aes_done  in  1  one-cycle strobe; `aes_result` is valid in that cycle.
- aes_result  in  128  ciphertext.
- sym_time  out  16  symbol length to the modulator, {MSB byte, LSB byte}.
- bit_data  out  1  bit to modulate.
- bit_valid  out  1  bit offered to the modulator.
- bit_ready  in  1  modulator accepts the bit; transfer occurs when `bit_valid && bit_ready`.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky flag: a byte arrived while in ENCRYPT or TRANSMIT.

## Operation
States and transitions:
- IDLE: on `rx_valid`, store the byte at index 0 and go to COLLECT.
- COLLECT: store bytes 1..15 into `aes_block`, byte 16 into `sym_time[15:8]`, byte 17 into `sym_time[7:0]`, byte 18 into `rep`.
  - The byte counter is 5 bits wide.
  - On byte 18, go to ENCRYPT and assert `aes_start` in the next cycle.
- ENCRYPT: wait for `aes_done`. Capture `aes_result` into the shift register, then go to TRANSMIT.
- TRANSMIT:
  - `bit_data` = shreg[127]. `bit_valid` stays high until the transfer completes.
  - On each transfer, increment the repetition counter.
  - When the repetition counter reaches `eff_rep`, shift left by 1, clear the counter and increment the 7-bit bit counter.
  - After the transfer of bit 127 at repetition `eff_rep`, go to IDLE.

Rules:
- `eff_rep` = `rep`, except `rep` == 0 is treated as 1. Total transfers = 128 × `eff_rep`, at most 32640.
- `rx_valid` in ENCRYPT or TRANSMIT: the byte is dropped and `overrun` is set. `overrun` clears on the first byte accepted in IDLE.
- `aes_done` outside ENCRYPT is ignored.
- `sym_time`, `rep` and `aes_block` hold their values until overwritten by the next frame.
- Simultaneous `rx_valid` and `aes_done` in ENCRYPT: both are honoured (drop and flag the byte, capture the result).

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-operation aborts any frame, encryption or transmission within one cycle.
- `aes_start` is high exactly one cycle: the cycle after the 19th `rx_valid`.
- `bit_valid` rises the cycle after `aes_done`.
- Handshake: `bit_data` may change only in the cycle after a transfer. `bit_valid` never drops without a transfer.
- `busy` falls the cycle after the final transfer.
- Back-to-back `rx_valid` on consecutive cycles must be accepted.

## Configuration
- FSK_SEQ_TIMEOUT_EN defined:
  - A 23-bit idle counter runs in COLLECT and resets on each `rx_valid`.
  - Reaching TIMEOUT_CYCLES discards the partial frame and returns to IDLE.
  - `aes_block`, `sym_time` and `rep` keep their partially written contents.
- FSK_SEQ_TIMEOUT_EN undefined: no counter. COLLECT waits indefinitely.

## Structure
- Shared package `fsk_tx_pkg`:
  - state enum (IDLE, COLLECT, ENCRYPT, TRANSMIT);
  - FRAME_BYTES = 19, BLOCK_BITS = 128;
  - byte-index constants IDX_SYM_MSB = 16, IDX_SYM_LSB = 17, IDX_REP = 18.
- One natural sub-module: `fsk_bit_serializer`. It holds the shift register, the repetition and bit counters and the valid/ready handshake, and has load/done ports. The FSM and frame capture stay in the top.

## Test plan
- Frame = DEADBEEF×4, sym 0x000A, rep 1 → `aes_block` = {DEADBEEF×4}, `sym_time` = 0x000A. One `aes_start` pulse one cycle after byte 19. With `aes_result` = 0x8000…0001, exactly 128 transfers with first bit 1, bits 2–127 0, last bit 1. `busy` low afterwards.
- Same frame, rep 3, `bit_ready` toggled randomly → 384 transfers, each bit repeated 3× consecutively. `bit_data` stable while `bit_valid` && !`bit_ready`.
- rep 0 → 128 transfers, identical to rep 1.
- Byte 0x55 injected during ENCRYPT and again during TRANSMIT → `overrun` = 1, transfer count unchanged. The next frame's first byte clears `overrun`.
- M_RESET asserted after transfer 50 → next cycle all outputs 0 and state IDLE. A following full frame transmits correctly.
- With FSK_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 100: send 5 bytes, idle 100 cycles → `busy` falls and no `aes_start` occurs. A fresh 19-byte frame then starts encryption normally.
